alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Integer execute stage directly downstream of the reservation station. Accepts one ready
//  instruction per cycle (operands already resolved), computes a 32-bit result, and queues
//  it in a small result FIFO. Drains one result per granted cycle onto the common data bus (CDB).
//  Applies back-pressure to the RS via alu_stall.
// PARAMETERS
//  ROB_SIZE_BIT  4  width of ROB tag
//  RS_TYPE_BIT   4  width of op code (arith_type)
//  FIFO_DEPTH    4  result queue entries; power of two, >=2
// PORTS
//  clk_in       in   1             system clock; all state updates on rising edge
//  rst_in       in   1             synchronous, active-high reset
//  rdy_in       in   1             global enable; low = freeze all state
//  rob_clear    in   1             misprediction flush
//  alu_input    in   1             RS issues an instruction this cycle
//  arith_type   in   RS_TYPE_BIT   op code
//  r1_val       in   32            operand 1
//  r2_val       in   32            operand 2 (register or immediate)
//  inst_rob_id  in   ROB_SIZE_BIT  ROB tag of the issued instruction
//  alu_stall    out  1             queue full; RS must not issue
//  cdb_valid    out  1             head result present on CDB
//  cdb_rob_id   out  ROB_SIZE_BIT  tag of head result
//  cdb_value    out  32            value of head result
//  cdb_grant    in   1             CDB arbiter accepts head this cycle
// BEHAVIOUR
//  Ops (arith_type): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount
//  r2_val[4:0]), 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 GE, 13 GEU (compares give 32'd1/32'd0),
//  14 MUL (see CONFIGURATION), 15 reserved -> result 32'd0. Arithmetic mod 2^32, no flags.
//  Reset (rst_in=1 at edge): FIFO empty, count=0, rd/wr ptr=0 -> cdb_valid=0, cdb_rob_id=0,
//  cdb_value=0, alu_stall=0. Reset dominates rdy_in and all other inputs.
//  rdy_in=0: no state changes; outputs hold; grant and alu_input ignored.
//  Push: edge where rdy_in && alu_input && !alu_stall && !rob_clear writes {tag,result}.
//  Latency: issue in cycle N with empty FIFO -> cdb_valid=1 with that result in cycle N+1.
//  Pop: edge where rdy_in && cdb_valid && cdb_grant && !rob_clear advances head.
//  Push and pop on same edge: count unchanged; pointers wrap modulo FIFO_DEPTH.
//  cdb_valid = (count != 0); cdb_rob_id/cdb_value driven from head entry (zero when empty).
//  alu_stall = (count == FIFO_DEPTH), from registered count only (no grant path, no comb loop
//  to RS). alu_input while alu_stall=1: dropped, no state change (RS protocol violation).
//  Order: results leave in issue order; no bypass of the FIFO.
//  rob_clear && rdy_in: FIFO emptied (count=0, ptrs=0) at that edge; same-cycle issue and
//  grant are discarded; cdb_valid=0 next cycle. rob_clear with rdy_in=0: ignored.
// CONFIGURATION
//  ALU_MUL_EN defined: op 14 = low 32 bits of r1_val*r2_val, same single-cycle latency.
//  ALU_MUL_EN undefined: op 14 treated as reserved -> result 32'd0; no multiplier inferred.
// TESTING
//  1. Reset, then issue ADD 5+7 tag 3, grant=1 -> next cycle cdb_valid=1, tag 3, value 12;
//     following cycle cdb_valid=0.
//  2. grant=0, issue 4 SUBs (10-3, tags 0..3) -> alu_stall=1 after 4th; 5th issue dropped;
//     grant=1 -> values 7 x4 drained in tag order 0,1,2,3, alu_stall falls after first pop.
//  3. SRA 0x80000000>>4 -> 0xF8000000; SRL same -> 0x08000000; SLT -1,1 -> 1; SLTU -1,1 -> 0.
//  4. FIFO holds 2 entries, rob_clear=1 with alu_input=1 and grant=1 -> next cycle
//     cdb_valid=0, count=0, issued entry not present.
//  5. rdy_in=0 for 3 cycles with alu_input=1, grant=1 -> outputs and count unchanged.
//  6. Op 14, 0x10000 * 0x10001 -> 0x00010000 with ALU_MUL_EN, 0x00000000 without.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: RS issue and CDB result signals of the integer execute stage
interface alu_exec_unit_if #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 4
);
    logic                    alu_input;
    logic [RS_TYPE_BIT-1:0]  arith_type;
    logic [31:0]             r1_val;
    logic [31:0]             r2_val;
    logic [ROB_SIZE_BIT-1:0] inst_rob_id;
    logic                    alu_stall;
    logic                    cdb_valid;
    logic [ROB_SIZE_BIT-1:0] cdb_rob_id;
    logic [31:0]             cdb_value;
    logic                    cdb_grant;

    modport master (
        output alu_input, arith_type, r1_val, r2_val, inst_rob_id, cdb_grant,
        input  alu_stall, cdb_valid, cdb_rob_id, cdb_value
    );

    modport slave (
        input  alu_input, arith_type, r1_val, r2_val, inst_rob_id, cdb_grant,
        output alu_stall, cdb_valid, cdb_rob_id, cdb_value
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle integer ALU whose results queue in a FIFO draining onto the CDB.
// Defining ALU_MUL_EN makes op 14 a 32x32 multiply (low word); otherwise op 14 yields zero.
module alu_exec_unit #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int RS_TYPE_BIT  = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           rob_clear,
    alu_exec_unit_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [RS_TYPE_BIT-1:0]  op;
    logic [31:0]             a;
    logic [31:0]             b;
    logic [4:0]              sh;
    logic [31:0]             result;
    logic [ROB_SIZE_BIT-1:0] tag_mem [FIFO_DEPTH];
    logic [31:0]             val_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W:0]          count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;

    assign op    = bus.arith_type;
    assign a     = bus.r1_val;
    assign b     = bus.r2_val;
    assign sh    = bus.r2_val[4:0];
    assign full  = count == (PTR_W+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    // Stall comes only from the registered count, so the RS never sees a grant-dependent path.
    assign push  = rdy_in && bus.alu_input && !full && !rob_clear;
    assign pop   = rdy_in && !empty && bus.cdb_grant && !rob_clear;

    assign bus.alu_stall  = full;
    assign bus.cdb_valid  = !empty;
    assign bus.cdb_rob_id = empty ? '0 : tag_mem[rd_ptr];
    assign bus.cdb_value  = empty ? '0 : val_mem[rd_ptr];

    // Decode the op code and compute the result of the instruction being issued
    always_comb begin
        result = '0;
        case (32'(op))
            0:  result = a + b;
            1:  result = a - b;
            2:  result = a & b;
            3:  result = a | b;
            4:  result = a ^ b;
            5:  result = a << sh;
            6:  result = a >> sh;
            7:  result = $signed(a) >>> sh;
            8:  result = {31'd0, $signed(a) < $signed(b)};
            9:  result = {31'd0, a < b};
            10: result = {31'd0, a == b};
            11: result = {31'd0, a != b};
            12: result = {31'd0, $signed(a) >= $signed(b)};
            13: result = {31'd0, a >= b};
`ifdef ALU_MUL_EN
            14: result = a * b;
`endif
            default: result = '0;
        endcase
    end

    // Result storage; stale entries are masked by the count, so no reset is needed
    always_ff @(posedge clk_in) begin
        if (push) begin
            tag_mem[wr_ptr] <= bus.inst_rob_id;
            val_mem[wr_ptr] <= result;
        end
    end

    // Queue pointers and occupancy; a flush discards the same-cycle issue and grant
    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && rob_clear)) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench with a queue model of the result FIFO and a reference ALU
module tb_alu_exec_unit;
    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
    } ent_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic rob_clear;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    ent_t exp_q[$];
    ent_t m_e;
    logic        pv = 1'b0;
    logic [3:0]  pt = '0;
    logic [31:0] pval = '0;

    always #5 clk_in = ~clk_in;

    alu_exec_unit_if #(.ROB_SIZE_BIT(4), .RS_TYPE_BIT(4)) bus ();

    alu_exec_unit #(.ROB_SIZE_BIT(4), .RS_TYPE_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .rob_clear(rob_clear),
        .bus      (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa = int'(a);
        int     sb = int'(b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        int     sh = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'(sa >>> sh);
            4'd8:  return {31'd0, sa < sb};
            4'd9:  return {31'd0, ua < ub};
            4'd10: return {31'd0, a == b};
            4'd11: return {31'd0, a != b};
            4'd12: return {31'd0, sa >= sb};
            4'd13: return {31'd0, ua >= ub};
`ifdef ALU_MUL_EN
            4'd14: return 32'(ua * ub);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of stimulus at the falling edge and record the expected result if accepted
    task automatic step(input logic rdy, input logic clr, input logic in, input logic grant,
                        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] expv);
        @(negedge clk_in);
        rdy_in          = rdy;
        rob_clear       = clr;
        bus.alu_input   = in;
        bus.cdb_grant   = grant;
        bus.arith_type  = op;
        bus.r1_val      = a;
        bus.r2_val      = b;
        bus.inst_rob_id = tag;
        if (rdy && in && !clr && exp_q.size() < 4) exp_q.push_back('{tag, expv});
    endtask

    task automatic issue(input logic grant, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input logic [31:0] expv);
        step(1'b1, 1'b0, 1'b1, grant, op, a, b, tag, expv);
    endtask

    task automatic idle(input logic grant, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, grant, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0);
    endtask

    // Monitor: after each edge, retire the result the DUT offered if it was granted, then check state
    always @(posedge clk_in) begin
        #1;
        if (mon_en) begin
            if (rdy_in && rob_clear) begin
                exp_q.delete();
            end else if (rdy_in && bus.cdb_grant && pv) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cdb_unexpected: got tag %h value %h expected no result at %0t", pt, pval, $time);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("cdb_tag", 32'(pt), 32'(m_e.tag));
                    chk("cdb_value", pval, m_e.val);
                end
            end
            chk("cdb_valid", 32'(bus.cdb_valid), 32'(exp_q.size() != 0));
            chk("alu_stall", 32'(bus.alu_stall), 32'(exp_q.size() == 4));
            if (exp_q.size() == 0) begin
                chk("empty_tag", 32'(bus.cdb_rob_id), 32'd0);
                chk("empty_value", bus.cdb_value, 32'd0);
            end else begin
                chk("head_tag", 32'(bus.cdb_rob_id), 32'(exp_q[0].tag));
                chk("head_value", bus.cdb_value, exp_q[0].val);
            end
        end
        pv   = bus.cdb_valid;
        pt   = bus.cdb_rob_id;
        pval = bus.cdb_value;
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_in          = 1'b1;
        rdy_in          = 1'b1;
        rob_clear       = 1'b0;
        bus.alu_input   = 1'b1;
        bus.cdb_grant   = 1'b0;
        bus.arith_type  = 4'd0;
        bus.r1_val      = 32'd1;
        bus.r2_val      = 32'd2;
        bus.inst_rob_id = 4'd9;
        repeat (3) @(negedge clk_in);
        chk("reset_valid", 32'(bus.cdb_valid), 32'd0);
        chk("reset_tag", 32'(bus.cdb_rob_id), 32'd0);
        chk("reset_value", bus.cdb_value, 32'd0);
        chk("reset_stall", 32'(bus.alu_stall), 32'd0);
        rst_in        = 1'b0;
        bus.alu_input = 1'b0;
        mon_en        = 1'b1;

        issue(1'b1, 4'd0, 32'd5, 32'd7, 4'd3, 32'd12);
        idle(1'b1, 2);

        for (int i = 0; i < 4; i++) issue(1'b0, 4'd1, 32'd10, 32'd3, 4'(i), 32'd7);
        issue(1'b0, 4'd1, 32'd10, 32'd3, 4'd5, 32'd7);
        idle(1'b1, 5);

        issue(1'b1, 4'd7, 32'h8000_0000, 32'd4, 4'd1, 32'hF800_0000);
        issue(1'b1, 4'd6, 32'h8000_0000, 32'd4, 4'd2, 32'h0800_0000);
        issue(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1);
        issue(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0);
        issue(1'b1, 4'd15, 32'h1234_5678, 32'd9, 4'd5, 32'd0);
`ifdef ALU_MUL_EN
        issue(1'b1, 4'd14, 32'h0001_0000, 32'h0001_0001, 4'd6, 32'h0001_0000);
`else
        issue(1'b1, 4'd14, 32'h0001_0000, 32'h0001_0001, 4'd6, 32'h0000_0000);
`endif
        idle(1'b1, 2);

        issue(1'b0, 4'd0, 32'd1, 32'd1, 4'd7, 32'd2);
        issue(1'b0, 4'd0, 32'd2, 32'd2, 4'd8, 32'd4);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 32'd3, 32'd3, 4'd9, 32'd6);
        idle(1'b1, 2);

        issue(1'b0, 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd10, 32'hF000_F000);
        issue(1'b0, 4'd4, 32'hAAAA_AAAA, 32'h5555_5555, 4'd11, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'd4, 32'd4, 4'd12, 32'd8);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0);
        idle(1'b1, 3);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom % 4 == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
            b  = ($urandom % 4 == 0) ? a : $urandom;
            step($urandom % 8 != 0, $urandom % 25 == 0, $urandom % 4 != 0, 1'($urandom % 2),
                 op, a, b, 4'($urandom_range(0, 15)), ref_alu(op, a, b));
        end
        idle(1'b1, 6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
